rt_ibex_pcs_rf_restore: RTL and testbench
=========================================

// Module: rt_ibex_pcs_rf_restore
// PURPOSE
// - Write-back end of the PCS context save/restore path. Consumes the restore beat from the
//   context LIFO (restore_en_i / restore_data_i) and writes the popped registers back into the
//   core register file over NrWrPorts dedicated write ports, one group per granted cycle.
// - Stalls mret retirement until every saved register is back in the RF.
// PARAMETERS
// - NrSavedRegs   9                   number of context registers per restore beat
// - DataWidth     32                  register width
// - NrWrPorts     1                   RF write ports used per cycle; legal values 1 or 2
// - SavedRegAddr  {14,13,12,11,10,7,6,5,1}  RF address of restore_data_i[i] (entry i = LSB-first)
// PORTS
// - clk_i           in   1                          clock
// - rst_i           in   1                          synchronous reset, active-high
// - restore_en_i    in   1                          LIFO restore beat valid
// - restore_data_i  in   NrSavedRegs x DataWidth    popped context, entry i -> SavedRegAddr[i]
// - rf_gnt_i        in   1                          RF write ports free this cycle (no core write)
// - rf_we_o         out  NrWrPorts                  per-port write enable
// - rf_waddr_o      out  NrWrPorts x 5              per-port write address
// - rf_wdata_o      out  NrWrPorts x DataWidth      per-port write data
// - stall_o         out  1                          hold mret retirement / IF
// - busy_o          out  1                          state != IDLE
// - done_o          out  1                          one-cycle pulse, restore complete
// - overrun_o       out  1                          sticky: restore_en_i seen while busy
// - rf_raddr_i      in   5                          core RF read address (bypass, see CONFIG)
// - byp_hit_o       out  1                          bypass data valid for rf_raddr_i
// - byp_data_o      out  DataWidth                  bypass data
// BEHAVIOUR
// - Reset (rst_i=1 at posedge): state IDLE, idx=0, buffer cleared, overrun_o=0. Combinationally
//   during reset all outputs are 0. A reset mid-restore abandons it: no further writes, no done_o.
// - FSM states: IDLE, WRITE, DONE.
// - IDLE: if restore_en_i: latch restore_data_i into buffer, idx<=0, -> WRITE. stall_o =
//   restore_en_i (combinational, so the beat cycle is already stalled). rf_we_o=0.
// - WRITE: port p drives entry idx+p. rf_we_o[p] = rf_gnt_i && (idx+p < NrSavedRegs).
//   On a granted cycle idx += NrWrPorts. Transition to DONE on the granted cycle whose
//   group contains entry NrSavedRegs-1. No grant -> outputs held, rf_we_o=0, idx unchanged.
//   Odd NrSavedRegs with 2 ports: final cycle port1 we=0.
// - DONE: done_o=1 for this cycle only, stall_o=1, -> IDLE. stall_o=0 from the next cycle.
// - stall_o = (state != IDLE) || (state==IDLE && restore_en_i). busy_o = (state != IDLE).
// - Latency with rf_gnt_i=1: beat at cycle 0, writes cycles 1..ceil(N/P), done_o at cycle
//   ceil(N/P)+1, stall_o low from ceil(N/P)+2. Defaults: writes 1..9, done_o cycle 10.
// - restore_en_i while in WRITE or DONE: ignored (buffer untouched), overrun_o <= 1 (sticky).
//   LIFO holding restore_en_i high beyond the beat counts as overrun only after leaving IDLE;
//   the LIFO pulses restore_en_i for exactly one cycle per beat.
// - Write order strictly ascending entry index; addresses taken from SavedRegAddr, not computed.
// CONFIGURATION
// - RT_IBEX_PCS_RESTORE_BYPASS_EN defined: in WRITE, if rf_raddr_i == SavedRegAddr[k] for an
//   entry k not yet written (k >= idx, or k in current ungranted group), byp_hit_o=1 and
//   byp_data_o = buffer[k]; entries written this granted cycle also hit. Else hit=0, data=0.
// - Not defined: byp_hit_o=0, byp_data_o=0 constant; ports remain for stable integration.
// TESTING
// - Defaults, rf_gnt_i=1, beat data[i]=32'hA0+i -> writes x1=A0,x5=A1,..,x14=A8 cycles 1..9,
//   done_o at cycle 10 only, stall_o high cycles 0..10.
// - rf_gnt_i low on cycles 3 and 4 -> x6 write slips to cycle 5, done_o at cycle 12, no dup writes.
// - NrWrPorts=2, N=9 -> 5 write cycles, cycle 5 port1 we=0, done_o at cycle 6.
// - Second restore_en_i at cycle 4 with different data -> ignored, overrun_o=1 until rst_i,
//   written values still A0..A8.
// - rst_i asserted at cycle 5 -> from cycle 6 rf_we_o=0, stall_o=0, done_o never pulses, idx=0.
// - BYPASS_EN: rf_raddr_i=14 at cycle 2 -> byp_hit_o=1, byp_data_o=A8; at cycle 10 hit=0.

Source files
------------

// File: rtl/rt_ibex_pcs_rf_restore.sv
// Write-back stage of the PCS context restore: drains one popped LIFO beat into the RF and
// stalls mret until done. Optional read bypass when RT_IBEX_PCS_RESTORE_BYPASS_EN is defined.
module rt_ibex_pcs_rf_restore #(
  parameter int unsigned                  NrSavedRegs  = 9,
  parameter int unsigned                  DataWidth    = 32,
  parameter int unsigned                  NrWrPorts    = 1,
  parameter logic [NrSavedRegs-1:0][4:0]  SavedRegAddr = {5'd14, 5'd13, 5'd12, 5'd11, 5'd10,
                                                          5'd7, 5'd6, 5'd5, 5'd1}
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 restore_en_i,
  input  logic [NrSavedRegs-1:0][DataWidth-1:0] restore_data_i,
  input  logic                                 rf_gnt_i,
  output logic [NrWrPorts-1:0]                 rf_we_o,
  output logic [NrWrPorts-1:0][4:0]            rf_waddr_o,
  output logic [NrWrPorts-1:0][DataWidth-1:0]  rf_wdata_o,
  output logic                                 stall_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 overrun_o,
  input  logic [4:0]                           rf_raddr_i,
  output logic                                 byp_hit_o,
  output logic [DataWidth-1:0]                 byp_data_o
);

  localparam int unsigned IdxW = $clog2(NrSavedRegs + NrWrPorts + 1);
  localparam int unsigned EntW = (NrSavedRegs > 1) ? $clog2(NrSavedRegs) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_e;

  state_e                               state_q, state_d;
  logic [IdxW-1:0]                      idx_q, idx_d;
  logic [NrSavedRegs-1:0][DataWidth-1:0] buf_q;
  logic                                 overrun_q;
  logic                                 load;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      // NOTE: the buffer is cleared too, so a context abandoned by reset can never resurface
      // through the write or bypass paths.
      buf_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this block order-independent.
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) buf_q <= restore_data_i;
      if (restore_en_i && (state_q != IDLE)) overrun_q <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    load       = 1'b0;
    rf_we_o    = '0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    unique case (state_q)
      IDLE: begin
        if (restore_en_i) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // Port p carries entry idx+p; address and data stay on the ports while the grant is low.
        for (int unsigned p = 0; p < NrWrPorts; p++) begin
          if (32'(idx_q) + p < NrSavedRegs) begin
            rf_waddr_o[p] = SavedRegAddr[EntW'(32'(idx_q) + p)];
            rf_wdata_o[p] = buf_q[EntW'(32'(idx_q) + p)];
            rf_we_o[p]    = rf_gnt_i;
          end
        end
        if (rf_gnt_i) begin
          idx_d = idx_q + IdxW'(NrWrPorts);
          if (32'(idx_q) + NrWrPorts >= NrSavedRegs) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      rf_we_o    = '0;
      rf_waddr_o = '0;
      rf_wdata_o = '0;
    end
  end

  assign busy_o    = !rst_i && (state_q != IDLE);
  assign stall_o   = !rst_i && ((state_q != IDLE) || restore_en_i);
  assign done_o    = !rst_i && (state_q == DONE);
  assign overrun_o = !rst_i && overrun_q;

`ifdef RT_IBEX_PCS_RESTORE_BYPASS_EN
  // Entries from idx upward are not yet committed (or are being committed this cycle).
  always_comb begin
    byp_hit_o  = 1'b0;
    byp_data_o = '0;
    if (!rst_i && (state_q == WRITE)) begin
      for (int unsigned k = 0; k < NrSavedRegs; k++) begin
        if (!byp_hit_o && (k >= 32'(idx_q)) && (rf_raddr_i == SavedRegAddr[EntW'(k)])) begin
          byp_hit_o  = 1'b1;
          byp_data_o = buf_q[EntW'(k)];
        end
      end
    end
  end
`else
  logic unused_raddr;
  assign unused_raddr = ^rf_raddr_i;
  assign byp_hit_o    = 1'b0;
  assign byp_data_o   = '0;
`endif

endmodule

// File: tb/tb_rt_ibex_pcs_rf_restore.sv
// Bench for rt_ibex_pcs_rf_restore: 1-port and 2-port instances against a pending-write queue
// model, plus directed literal expectations on timing and written values.
module tb_rt_ibex_pcs_rf_restore;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  restore_en_i;
  logic [8:0][31:0]      restore_data_i;
  logic                  rf_gnt_i;
  logic [4:0]            rf_raddr_i;

  logic [0:0]            we1;
  logic [0:0][4:0]       wa1;
  logic [0:0][31:0]      wd1;
  logic                  stall1, busy1, done1, ovr1, hit1;
  logic [31:0]           bd1;

  logic [1:0]            we2;
  logic [1:0][4:0]       wa2;
  logic [1:0][31:0]      wd2;
  logic                  stall2, busy2, done2, ovr2, hit2;
  logic [31:0]           bd2;

  rt_ibex_pcs_rf_restore #(.NrWrPorts(1)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .restore_en_i(restore_en_i), .restore_data_i(restore_data_i),
    .rf_gnt_i(rf_gnt_i), .rf_we_o(we1), .rf_waddr_o(wa1), .rf_wdata_o(wd1), .stall_o(stall1),
    .busy_o(busy1), .done_o(done1), .overrun_o(ovr1), .rf_raddr_i(rf_raddr_i),
    .byp_hit_o(hit1), .byp_data_o(bd1)
  );

  rt_ibex_pcs_rf_restore #(.NrWrPorts(2)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .restore_en_i(restore_en_i), .restore_data_i(restore_data_i),
    .rf_gnt_i(rf_gnt_i), .rf_we_o(we2), .rf_waddr_o(wa2), .rf_wdata_o(wd2), .stall_o(stall2),
    .busy_o(busy2), .done_o(done2), .overrun_o(ovr2), .rf_raddr_i(rf_raddr_i),
    .byp_hit_o(hit2), .byp_data_o(bd2)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: each instance holds a queue of pending (addr,data) writes drained P per granted cycle.
  logic [4:0]  addr_tbl [9] = '{5'd1, 5'd5, 5'd6, 5'd7, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
  int          ph   [2] = '{0, 0};   // 0 idle, 1 writing, 2 done pulse
  logic [4:0]  pa   [2][9];
  logic [31:0] pd   [2][9];
  int          head [2] = '{0, 0};
  int          cnt  [2] = '{0, 0};
  logic        ovr  [2] = '{1'b0, 1'b0};

  // Statistics gathered from DUT activity for the literal expectations.
  logic [31:0] shadow     [2][32];
  int          wr_cyc     [2][32];
  int          wcount     [2];
  int          done_cyc   [2];
  int          last_stall [2];
  logic        byp2_hit, byp10_hit;
  logic [31:0] byp2_data;

  logic [1:0]       a_we, e_we, e_has;
  logic [1:0][4:0]  a_wa, e_wa;
  logic [1:0][31:0] a_wd, e_wd;
  logic             a_st, a_bs, a_dn, a_ov, a_hit, e_st, e_bs, e_dn, e_ov, e_hit;
  logic [31:0]      a_bd, e_bd;

  always @(negedge clk_i) begin
    for (int m = 0; m < 2; m++) begin
      if (m == 0) begin
        a_we = {1'b0, we1}; a_wa[0] = wa1[0]; a_wa[1] = '0; a_wd[0] = wd1[0]; a_wd[1] = '0;
        a_st = stall1; a_bs = busy1; a_dn = done1; a_ov = ovr1; a_hit = hit1; a_bd = bd1;
      end else begin
        a_we = we2; a_wa = wa2; a_wd = wd2;
        a_st = stall2; a_bs = busy2; a_dn = done2; a_ov = ovr2; a_hit = hit2; a_bd = bd2;
      end

      e_we = '0; e_has = '0; e_wa = '0; e_wd = '0;
      e_st = 1'b0; e_bs = 1'b0; e_dn = 1'b0; e_hit = 1'b0; e_bd = '0;
      if (!rst_i) begin
        case (ph[m])
          0: e_st = restore_en_i;
          1: begin
            e_st = 1'b1; e_bs = 1'b1;
            for (int p = 0; p <= m; p++) begin
              if (p < cnt[m]) begin
                e_has[p] = 1'b1;
                e_wa[p]  = pa[m][head[m] + p];
                e_wd[p]  = pd[m][head[m] + p];
                e_we[p]  = rf_gnt_i;
              end
            end
`ifdef RT_IBEX_PCS_RESTORE_BYPASS_EN
            for (int k = head[m]; k < head[m] + cnt[m]; k++) begin
              if (!e_hit && pa[m][k] == rf_raddr_i) begin
                e_hit = 1'b1;
                e_bd  = pd[m][k];
              end
            end
`endif
          end
          default: begin e_st = 1'b1; e_bs = 1'b1; e_dn = 1'b1; end
        endcase
      end
      e_ov = ovr[m] && !rst_i;

      check($sformatf("p%0d_stall", m + 1), 64'(a_st), 64'(e_st));
      check($sformatf("p%0d_busy", m + 1), 64'(a_bs), 64'(e_bs));
      check($sformatf("p%0d_done", m + 1), 64'(a_dn), 64'(e_dn));
      check($sformatf("p%0d_overrun", m + 1), 64'(a_ov), 64'(e_ov));
      check($sformatf("p%0d_we", m + 1), 64'(a_we), 64'(e_we));
      check($sformatf("p%0d_byp_hit", m + 1), 64'(a_hit), 64'(e_hit));
      check($sformatf("p%0d_byp_data", m + 1), 64'(a_bd), 64'(e_bd));
      for (int p = 0; p <= m; p++) begin
        if (e_has[p]) begin
          check($sformatf("p%0d_waddr%0d", m + 1, p), 64'(a_wa[p]), 64'(e_wa[p]));
          check($sformatf("p%0d_wdata%0d", m + 1, p), 64'(a_wd[p]), 64'(e_wd[p]));
        end
      end

      if (cyc >= 0) begin
        for (int p = 0; p <= m; p++) begin
          if (a_we[p] === 1'b1) begin
            shadow[m][a_wa[p]] = a_wd[p];
            wr_cyc[m][a_wa[p]] = cyc;
            wcount[m]++;
          end
        end
        if (a_dn === 1'b1 && done_cyc[m] < 0) done_cyc[m] = cyc;
        if (a_st === 1'b1) last_stall[m] = cyc;
        if (m == 0 && cyc == 2)  begin byp2_hit = a_hit; byp2_data = a_bd; end
        if (m == 0 && cyc == 10) byp10_hit = a_hit;
      end

      if (rst_i) begin
        ph[m] = 0; head[m] = 0; cnt[m] = 0; ovr[m] = 1'b0;
      end else begin
        if (ph[m] != 0 && restore_en_i) ovr[m] = 1'b1;
        case (ph[m])
          0: if (restore_en_i) begin
            for (int k = 0; k < 9; k++) begin
              pa[m][k] = addr_tbl[k];
              pd[m][k] = restore_data_i[k];
            end
            head[m] = 0; cnt[m] = 9; ph[m] = 1;
          end
          1: if (rf_gnt_i) begin
            int n;
            n = (cnt[m] < m + 1) ? cnt[m] : m + 1;
            head[m] += n; cnt[m] -= n;
            if (cnt[m] == 0) ph[m] = 2;
          end
          default: ph[m] = 0;
        endcase
      end
    end
  end

  task automatic clear_stats();
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 32; a++) begin shadow[m][a] = '0; wr_cyc[m][a] = -1; end
      wcount[m] = 0; done_cyc[m] = -1; last_stall[m] = -1;
    end
    byp2_hit = 1'bx; byp2_data = 'x; byp10_hit = 1'bx;
  endtask

  task automatic idle(input int n);
    cyc = -1; restore_en_i = 1'b0; rf_gnt_i = 1'b1; rst_i = 1'b0;
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  // One restore beat at cycle 0; optional grant gaps, second beat and reset cycle.
  task automatic run(input int ncyc, input int gnt_off_a, input int gnt_off_b,
                     input int beat2, input int rst_at);
    clear_stats();
    for (int c = 0; c < ncyc; c++) begin
      cyc          = c;
      restore_en_i = (c == 0) || (c == beat2);
      for (int i = 0; i < 9; i++) restore_data_i[i] = (c == 0) ? 32'hA0 + i : 32'hB0 + i;
      rf_gnt_i     = !(c == gnt_off_a || c == gnt_off_b);
      rst_i        = (c == rst_at);
      rf_raddr_i   = (c == 2 || c == 10) ? 5'd14 : 5'(c * 3);
      @(posedge clk_i); #1;
    end
    idle(2);
  endtask

  initial begin
    rst_i = 1'b1; restore_en_i = 1'b0; rf_gnt_i = 1'b1; restore_data_i = '0; rf_raddr_i = '0;
    clear_stats();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("reset_busy", 64'(busy1), 64'd0);
    check("reset_stall", 64'(stall1), 64'd0);
    check("reset_overrun", 64'(ovr2), 64'd0);
    idle(2);

    // Uninterrupted restore.
    run(14, -1, -1, -1, -1);
    check("t1_p1_done_cycle", 64'(done_cyc[0]), 64'd10);
    check("t1_p1_last_stall", 64'(last_stall[0]), 64'd10);
    check("t1_p1_writes", 64'(wcount[0]), 64'd9);
    check("t1_p1_x1", 64'(shadow[0][1]), 64'hA0);
    check("t1_p1_x14", 64'(shadow[0][14]), 64'hA8);
    check("t1_p1_x14_cycle", 64'(wr_cyc[0][14]), 64'd9);
    check("t1_p2_done_cycle", 64'(done_cyc[1]), 64'd6);
    check("t1_p2_writes", 64'(wcount[1]), 64'd9);
    check("t1_p2_x14_cycle", 64'(wr_cyc[1][14]), 64'd5);
    check("t1_p2_x10", 64'(shadow[1][10]), 64'hA4);
`ifdef RT_IBEX_PCS_RESTORE_BYPASS_EN
    check("t1_byp_hit_c2", 64'(byp2_hit), 64'd1);
    check("t1_byp_data_c2", 64'(byp2_data), 64'hA8);
    check("t1_byp_hit_c10", 64'(byp10_hit), 64'd0);
`else
    check("t1_byp_hit_c2", 64'(byp2_hit), 64'd0);
    check("t1_byp_data_c2", 64'(byp2_data), 64'd0);
`endif

    // Grant withheld on cycles 3 and 4.
    run(16, 3, 4, -1, -1);
    check("t2_p1_done_cycle", 64'(done_cyc[0]), 64'd12);
    check("t2_p1_x6_cycle", 64'(wr_cyc[0][6]), 64'd5);
    check("t2_p1_writes", 64'(wcount[0]), 64'd9);
    check("t2_p2_done_cycle", 64'(done_cyc[1]), 64'd8);

    // Second beat while busy: ignored, overrun sticks until reset.
    run(14, -1, -1, 4, -1);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t3_p1_x%0d", addr_tbl[i]), 64'(shadow[0][addr_tbl[i]]), 64'hA0 + i);
      check($sformatf("t3_p2_x%0d", addr_tbl[i]), 64'(shadow[1][addr_tbl[i]]), 64'hA0 + i);
    end
    check("t3_p1_overrun", 64'(ovr1), 64'd1);
    idle(3);
    check("t3_p2_overrun_sticky", 64'(ovr2), 64'd1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("t3_overrun_cleared", 64'(ovr1), 64'd0);
    idle(2);

    // Reset in the middle of the restore.
    run(14, -1, -1, -1, 5);
    check("t4_p1_no_done", 64'(done_cyc[0] < 0), 64'd1);
    check("t4_p2_no_done", 64'(done_cyc[1] < 0), 64'd1);
    check("t4_p1_writes", 64'(wcount[0]), 64'd4);
    check("t4_p2_writes", 64'(wcount[1]), 64'd8);
    check("t4_p1_last_stall", 64'(last_stall[0]), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
